// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI transfer controller.
//   - FSM state encodings, which are visible on the 'state' port
//   - command opcodes (upper nibble of the command byte)
//   - STATUS byte bit positions and the byte returned while the core runs
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SIZE   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_READ   = 3'd3,
    ST_RUN    = 3'd4,
    ST_RESULT = 3'd5
  } state_t;

  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_READ   = 4'h2;
  localparam logic [3:0] OP_RUN    = 4'h3;
  localparam logic [3:0] OP_RESULT = 4'h4;
  localparam logic [3:0] OP_STATUS = 4'h5;
  localparam logic [3:0] OP_CLEAR  = 4'h6;

  localparam int STATUS_BUSY_BIT = 7;
  localparam int STATUS_ERR_BIT  = 6;

  localparam logic [7:0] RUN_BUSY_BYTE = 8'h40;

  // {busy, error, 3'b0, state}
  function automatic logic [7:0] status_byte(input logic busy, input logic err,
                                             input logic [2:0] st);
    logic [7:0] b;
    b                  = '0;
    b[STATUS_BUSY_BIT] = busy;
    b[STATUS_ERR_BIT]  = err;
    b[2:0]             = st;
    return b;
  endfunction

endpackage

// File: rtl/spi_transfer_controller_v2_result_serializer.sv
// result_serializer: captures one result word on 'load' and presents one
// byte of it, chosen by byte_sel, zero-extended to RESULT_BYTES bytes.
// Ports:
//   clk, rst   clock / async active-low reset
//   load       capture results[idx] into the holding register
//   idx        result word index (must be < NUM_RESULTS when load is high)
//   results    flattened result words, index 0 at the LSBs
//   byte_sel   byte number of the held word (0 = least significant)
//   byte_out   selected byte
module result_serializer #(
  parameter int NUM_RESULTS  = 4,
  parameter int RESULT_W     = 35,
  parameter int RESULT_BYTES = 5,
  parameter int IDX_W        = 2,
  parameter int BSEL_W       = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [IDX_W-1:0]                idx,
  input  logic [NUM_RESULTS*RESULT_W-1:0] results,
  input  logic [BSEL_W-1:0]               byte_sel,
  output logic [7:0]                      byte_out
);

  logic [RESULT_W-1:0]       word_q;
  logic [RESULT_W-1:0]       word_sel;
  logic [RESULT_BYTES*8-1:0] word_ext;

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_RESULTS; i++) begin
      if (idx == IDX_W'(i)) word_sel = results[i*RESULT_W +: RESULT_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      word_q <= '0;
    else if (load) word_q <= word_sel;
  end

  always_comb begin
    word_ext               = '0;
    word_ext[RESULT_W-1:0] = word_q;
  end

  always_comb begin
    byte_out = '0;
    for (int b = 0; b < RESULT_BYTES; b++) begin
      if (byte_sel == BSEL_W'(b)) byte_out = word_ext[b*8 +: 8];
    end
  end

endmodule

// File: rtl/spi_transfer_controller_v2.sv
// SPI command controller sitting between spi_slave, the multi-channel image
// BRAM and the processing core. Commands arrive one byte per spi_cycle_done;
// the byte loaded into spi_byte_out is what the master clocks out on the
// following exchange.
// Ports:
//   clk, rst                 clock / async active-low reset
//   spi_cycle_done           one-clk pulse per SPI byte
//   spi_byte_in/out          received byte / byte for the next exchange
//   bram_addr/channel/we     BRAM address, channel select, write strobe
//   bram_data_in/out         BRAM write data / read data (1-clk latency)
//   results                  flattened result words from the core
//   proc_start/busy/done     core start pulse, busy flag, completion pulse
//   state                    current FSM state
//   error                    sticky error flag (cleared by CLEAR command)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE   0  | decode command byte
// SIZE   1  | collecting height hi/lo, width hi/lo
// WRITE  2  | streaming H*W bytes into the BRAM
// READ   3  | streaming H*W bytes out of the BRAM
// RUN    4  | core running, SPI bytes answered with 0x40
// RESULT 5  | sending RESULT_BYTES bytes of a result word, MSB first
module spi_transfer_controller_v2
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 17,
  parameter int NUM_CH       = 3,
  parameter int CH_W         = 2,
  parameter int NUM_RESULTS  = 4,
  parameter int RESULT_W     = 35,
  parameter int RESULT_BYTES = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            spi_cycle_done,
  input  logic [7:0]                      spi_byte_in,
  output logic [7:0]                      spi_byte_out,
  output logic [ADDR_W-1:0]               bram_addr,
  output logic [CH_W-1:0]                 bram_channel,
  output logic                            bram_we,
  output logic [7:0]                      bram_data_in,
  input  logic [7:0]                      bram_data_out,
  input  logic [NUM_RESULTS*RESULT_W-1:0] results,
  output logic                            proc_start,
  output logic                            proc_busy,
  input  logic                            proc_done,
  output logic [2:0]                      state,
  output logic                            error
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDX_W  = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
  localparam int BSEL_W = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;
  localparam logic [31:0]       DEPTH     = 32'd1 << ADDR_W;
  localparam logic [3:0]        MAX_CH    = 4'(NUM_CH);
  localparam logic [3:0]        MAX_IDX   = 4'(NUM_RESULTS);
  localparam logic [BSEL_W-1:0] LAST_BYTE = BSEL_W'(RESULT_BYTES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                we_q, we_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          sbo_q, sbo_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [15:0]         height_q, height_d;
  logic [15:0]         width_q, width_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [1:0]          size_cnt_q, size_cnt_d;
  logic [23:0]         size_buf_q, size_buf_d;
  logic [BSEL_W-1:0]   rcnt_q, rcnt_d;

  logic [3:0]          opcode, arg;
  logic                ch_ok;
  logic [15:0]         mul_h, mul_w;
  logic [31:0]         prod;
  logic                ser_load;
  logic [7:0]          ser_byte;

  assign opcode = spi_byte_in[7:4];
  assign arg    = spi_byte_in[3:0];
  assign ch_ok  = (arg != 4'd0) && (arg <= MAX_CH);

  // One multiplier: during SIZE it checks the incoming dimensions (the last
  // byte is still on spi_byte_in), otherwise it gives the stored image size.
  assign mul_h = (state_q == ST_SIZE) ? size_buf_q[23:8] : height_q;
  assign mul_w = (state_q == ST_SIZE) ? {size_buf_q[7:0], spi_byte_in} : width_q;
  assign prod  = {16'd0, mul_h} * {16'd0, mul_w};

  result_serializer #(
    .NUM_RESULTS  (NUM_RESULTS),
    .RESULT_W     (RESULT_W),
    .RESULT_BYTES (RESULT_BYTES),
    .IDX_W        (IDX_W),
    .BSEL_W       (BSEL_W)
  ) u_result_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .idx      (arg[IDX_W-1:0]),
    .results  (results),
    .byte_sel (LAST_BYTE - rcnt_q),
    .byte_out (ser_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '1;
      ch_q       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      sbo_q      <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      height_q   <= '0;
      width_q    <= '0;
      rem_q      <= '0;
      size_cnt_q <= '0;
      size_buf_q <= '0;
      rcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ch_q       <= ch_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      sbo_q      <= sbo_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      height_q   <= height_d;
      width_q    <= width_d;
      rem_q      <= rem_d;
      size_cnt_q <= size_cnt_d;
      size_buf_q <= size_buf_d;
      rcnt_q     <= rcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ch_d       = ch_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    sbo_d      = sbo_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    height_d   = height_q;
    width_d    = width_q;
    rem_d      = rem_q;
    size_cnt_d = size_cnt_q;
    size_buf_d = size_buf_q;
    rcnt_d     = rcnt_q;
    ser_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (spi_cycle_done) begin
          case (opcode)
            OP_WRITE: begin
              if (ch_ok) begin
                ch_d       = CH_W'(arg);
                size_cnt_d = '0;
                state_d    = ST_SIZE;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_READ: begin
              if (!ch_ok || prod == 32'd0) begin
                err_d = 1'b1;
              end else begin
                ch_d    = CH_W'(arg);
                addr_d  = '0;
                rem_d   = CNT_W'(prod);
                state_d = ST_READ;
              end
            end
            OP_RUN: begin
              start_d = 1'b1;
              busy_d  = 1'b1;
              state_d = ST_RUN;
            end
            OP_RESULT: begin
              if (arg < MAX_IDX) begin
                ser_load = 1'b1;
                rcnt_d   = '0;
                state_d  = ST_RESULT;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_STATUS: sbo_d = status_byte(busy_q, err_q, state_q);
            OP_CLEAR:  err_d = 1'b0;
            default:   err_d = 1'b1;
          endcase
        end
      end

      ST_SIZE: begin
        if (spi_cycle_done) begin
          size_buf_d = {size_buf_q[15:0], spi_byte_in};
          if (size_cnt_q == 2'd3) begin
            // Rejected sizes leave the previous dimensions in place.
            if (mul_h == 16'd0 || mul_w == 16'd0 || prod > DEPTH) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              height_d = mul_h;
              width_d  = mul_w;
              rem_d    = CNT_W'(prod);
              addr_d   = '1;  // first data byte wraps this to 0
              state_d  = ST_WRITE;
            end
          end else begin
            size_cnt_d = size_cnt_q + 2'd1;
          end
        end
      end

      ST_WRITE: begin
        if (spi_cycle_done) begin
          wdata_d = spi_byte_in;
          addr_d  = addr_q + 1'b1;
          we_d    = 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        // bram_data_out already reflects bram_addr: the address was set at
        // least one clk earlier because SPI bytes are >= 3 clk apart.
        if (spi_cycle_done) begin
          sbo_d  = bram_data_out;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (proc_done) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (spi_cycle_done) begin
          sbo_d = RUN_BUSY_BYTE;
        end
      end

      ST_RESULT: begin
        if (spi_cycle_done) begin
          sbo_d  = ser_byte;
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == LAST_BYTE) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign spi_byte_out = sbo_q;
  assign bram_addr    = addr_q;
  assign bram_channel = ch_q;
  assign bram_we      = we_q;
  assign bram_data_in = wdata_q;
  assign proc_start   = start_q;
  assign proc_busy    = busy_q;
  assign state        = state_q;
  assign error        = err_q;

endmodule

// File: doc/spi_transfer_controller_v2.md
Name: spi_transfer_controller_v2

Overview:
SPI command controller between spi_slave, the multi-channel image BRAM and the processing core (PDI). It generalises the first-generation controller: parametrised address depth, channel count and result count/width. Additions: stored image dimensions drive read-back length, bounds checking with an error flag, a status command, indexed multi-byte result readout and single-cycle write strobes.

Parameters:
ADDR_W, 17, BRAM address width; depth = 2**ADDR_W bytes per channel
NUM_CH, 3, image channels; channel field values 1..NUM_CH are valid
CH_W, 2, bram_channel width
NUM_RESULTS, 4, number of result words exposed for readout
RESULT_W, 35, width of each result word
RESULT_BYTES, 5, bytes sent per result = ceil(RESULT_W/8); zero-extended, MSB first

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
spi_cycle_done  in  1  one-clk pulse per SPI byte exchanged; min spacing 3 clk
spi_byte_in  in  8  byte received from spi_slave
spi_byte_out  out  8  byte loaded for the next SPI exchange
bram_addr  out  ADDR_W  BRAM address
bram_channel  out  CH_W  selected channel
bram_we  out  1  write strobe, one clk per data byte
bram_data_in  out  8  write data
bram_data_out  in  8  read data, 1-clk latency from bram_addr
results  in  NUM_RESULTS*RESULT_W  flattened result words; index 0 at LSBs
proc_start  out  1  one-clk start pulse to PDI
proc_busy  out  1  high from proc_start until proc_done
proc_done  in  1  PDI completion pulse
state  out  3  current FSM state
error  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0, except bram_addr = all ones. Stored height/width = 0. State = IDLE.
- Command byte layout: [7:4] opcode, [3:0] arg. All SPI-driven actions occur only in the clk where spi_cycle_done = 1.
- States: IDLE=0, SIZE=1, WRITE=2, READ=3, RUN=4, RESULT=5.
- IDLE, opcode decode:
  - 0x1 WRITE: arg = channel. Latch bram_channel, go to SIZE.
  - 0x2 READ: latch channel, set bram_addr = 0, go to READ. If stored H*W = 0, set error and stay in IDLE.
  - 0x3 RUN: proc_start = 1 for one clk, proc_busy = 1, go to RUN.
  - 0x4 RESULT: arg = index. Latch results[arg], byte counter = 0, go to RESULT. If arg >= NUM_RESULTS, set error and stay in IDLE.
  - 0x5 STATUS: spi_byte_out = {proc_busy, error, 3'b0, state}. Stay in IDLE.
  - 0x6 CLEAR: error = 0.
  - Any other opcode, or a channel of 0 or > NUM_CH: set error, stay in IDLE.
- SIZE: receive 4 bytes: height hi, height lo, width hi, width lo.
  - On the 4th byte, compute N = H*W as a 32-bit product.
  - If H = 0, W = 0, or N > 2**ADDR_W: set error, go to IDLE, keep the old dimensions.
  - Otherwise store H and W, set bram_addr = all ones, go to WRITE.
- WRITE: per byte, bram_data_in = byte, bram_addr += 1 (wraps from all ones to 0), bram_we = 1 for exactly one clk.
  - Track the remaining count. After the Nth byte go to IDLE.
- READ: per byte, spi_byte_out = bram_data_out, then bram_addr += 1.
  - Byte k exchanged in the next SPI cycle is mem[k].
  - After N bytes go to IDLE.
  - Read length always uses the stored dimensions.
- RESULT: per byte, spi_byte_out = byte[RESULT_BYTES-1-cnt] of the latched word. Go to IDLE after RESULT_BYTES bytes.
- RUN: each SPI byte returns 0x40. A proc_done pulse clears proc_busy and goes to IDLE.
  - If proc_done and spi_cycle_done coincide, proc_done wins and the byte is ignored.
  - A proc_done pulse outside RUN is ignored.
- Reset mid-transfer: immediate return to reset values. Partially written BRAM data is left as is.
- error stays set until CLEAR or reset.

Decomposition:
- spi_ctrl_pkg: opcode constants, state encodings, STATUS bit positions, RUN busy byte 0x40.
- One sub-module, result_serializer: latches the selected word and returns a byte by index. It is naturally separated because it is a parametrised slice/mux.

Test Plan:
- WRITE ch1, H=2, W=3, data 0x10..0x15 -> six bram_we pulses at addr 0..5 with data 0x10..0x15, channel=1, state returns to 0.
- READ ch1 after the above, BRAM preloaded -> exactly 6 bytes, mem[0..5] in order, then IDLE. bram_addr does not exceed 5 plus the final increment.
- WRITE with H=0x0200, W=0x0200 (N=262144 > 131072) -> error=1, no bram_we, dimensions unchanged. STATUS returns bit6 set. CLEAR then STATUS returns 0x00.
- RUN: proc_start pulse, bytes return 0x40. proc_done coinciding with spi_cycle_done -> proc_busy=0, state=0, byte ignored.
- RESULT idx2 with results[2]=35'h4_89AB_CDEF -> bytes 0x04, 0x89, 0xAB, 0xCD, 0xEF. idx7 -> error=1.
- Reset asserted after 3 WRITE bytes -> all outputs at reset values at once. A following READ with N=0 -> error.
